// File: rtl/boot_pkg.sv
// boot_pkg -- shared definitions for the CPU boot loader.
//   boot_state_t : loader/run-supervisor state encoding.
//   FIELD_*      : word positions inside a frame (ADDR, LEN, then data).
//   CKSUM_OK     : true when a frame's running word sum is zero.
package boot_pkg;

   typedef enum logic [2:0] {
      RX_ADDR,
      RX_LEN,
      RX_DATA,
      RX_CKSUM,
      RUN,
      DONE,
      ERROR
   } boot_state_t;

   // Frame layout: ADDR, LEN, LEN data words, CKSUM.
   localparam int FIELD_ADDR = 0;
   localparam int FIELD_LEN  = 1;
   localparam int FIELD_DATA = 2;

   // Widest stream word the checksum helper handles.
   localparam int CKSUM_W = 64;

   // The caller passes the mod-2^DATA_W sum of every frame word including
   // CKSUM, zero-extended; a good frame sums to zero.
   function automatic logic CKSUM_OK(input logic [CKSUM_W-1:0] frame_sum);
      return frame_sum == '0;
   endfunction

endpackage

// File: rtl/boot_run_timer.sv
// boot_run_timer -- counts cycles spent in RUN and flags the timeout cycle.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset.
//   enable      : high on every RUN cycle; the count advances on each.
//   clear       : zeroes the count (restart from DONE/ERROR).
//   max_cycles  : timeout limit, 0 disables the timeout.
//   count       : cycles counted so far (registered).
//   expired     : high in the RUN cycle whose edge takes count to max_cycles.
module boot_run_timer #(
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             clear,
   input  logic [CYC_W-1:0] max_cycles,
   output logic [CYC_W-1:0] count,
   output logic             expired
);

   logic [CYC_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + CYC_W'(1);
      end
   end

   assign count = count_reg;

   // Compare against max-1 so that the exit edge both leaves RUN and
   // brings the count to exactly max_cycles.
   assign expired = enable && (max_cycles != '0) &&
                    (count_reg == max_cycles - CYC_W'(1));

endmodule

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader -- loads framed program segments into CPU memory over a
// valid/ready word stream, then releases the core and supervises its run.
// Ports:
//   clk, rstn           : clock, synchronous active-low reset.
//   s_valid/s_data/s_ready : input word stream (transfer on valid & ready).
//   mem_we/mem_addr/mem_wdata : CPU memory write port, one write per data beat.
//   cpu_rstn, boot_pc   : core reset (low while loading/ERROR) and start PC.
//   cpu_halt, max_cycles: halt report from the core, run timeout (0 = off).
//   restart             : return to load mode from DONE or ERROR.
//   busy, done, err_cksum, err_timeout, seg_count, cycle_count : status.
// All outputs are registered.
module cpu_boot_loader
   import boot_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CYC_W  = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rstn,
   output logic [ADDR_W-1:0] boot_pc,
   input  logic              cpu_halt,
   input  logic [CYC_W-1:0]  max_cycles,
   input  logic              restart,
   output logic              busy,
   output logic              done,
   output logic              err_cksum,
   output logic              err_timeout,
   output logic [7:0]        seg_count,
   output logic [CYC_W-1:0]  cycle_count
);

   boot_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;     // next memory write address
   logic [ADDR_W-1:0] start_reg, start_next;   // ADDR field of current frame
   logic [DATA_W-1:0] left_reg, left_next;     // data words still expected
   logic [DATA_W-1:0] sum_reg, sum_next;       // running frame sum
   logic              term_reg, term_next;     // current frame has LEN = 0
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic [ADDR_W-1:0] boot_pc_reg, boot_pc_next;
   logic              err_cksum_reg, err_cksum_next;
   logic              err_timeout_reg, err_timeout_next;
   logic [7:0]        seg_count_reg, seg_count_next;
   logic              s_ready_reg, s_ready_next;
   logic              cpu_rstn_reg, cpu_rstn_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   logic              beat;
   logic              restart_take;
   logic              timer_expired;
   logic [DATA_W-1:0] frame_sum;

   assign beat      = s_valid && s_ready_reg;
   assign frame_sum = sum_reg + s_data;

   boot_run_timer #(.CYC_W(CYC_W)) u_timer (
      .clk        (clk),
      .rstn       (rstn),
      .enable     (state_reg == RUN),
      .clear      (restart_take),
      .max_cycles (max_cycles),
      .count      (cycle_count),
      .expired    (timer_expired)
   );

   assign restart_take = restart && ((state_reg == DONE) || (state_reg == ERROR));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg       <= RX_ADDR;
         addr_reg        <= '0;
         start_reg       <= '0;
         left_reg        <= '0;
         sum_reg         <= '0;
         term_reg        <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         boot_pc_reg     <= '0;
         err_cksum_reg   <= 1'b0;
         err_timeout_reg <= 1'b0;
         seg_count_reg   <= '0;
         s_ready_reg     <= 1'b1;
         cpu_rstn_reg    <= 1'b0;
         busy_reg        <= 1'b1;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         start_reg       <= start_next;
         left_reg        <= left_next;
         sum_reg         <= sum_next;
         term_reg        <= term_next;
         mem_we_reg      <= mem_we_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         boot_pc_reg     <= boot_pc_next;
         err_cksum_reg   <= err_cksum_next;
         err_timeout_reg <= err_timeout_next;
         seg_count_reg   <= seg_count_next;
         s_ready_reg     <= s_ready_next;
         cpu_rstn_reg    <= cpu_rstn_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      start_next       = start_reg;
      left_next        = left_reg;
      sum_next         = sum_reg;
      term_next        = term_reg;
      mem_we_next      = 1'b0;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      boot_pc_next     = boot_pc_reg;
      err_cksum_next   = err_cksum_reg;
      err_timeout_next = err_timeout_reg;
      seg_count_next   = seg_count_reg;

      case (state_reg)
         RX_ADDR: begin
            if (beat) begin
               start_next = s_data[ADDR_W-1:0];
               addr_next  = s_data[ADDR_W-1:0];
               sum_next   = s_data;
               state_next = RX_LEN;
            end
         end
         RX_LEN: begin
            if (beat) begin
               left_next  = s_data;
               sum_next   = frame_sum;
               term_next  = (s_data == '0);
               state_next = (s_data == '0) ? RX_CKSUM : RX_DATA;
            end
         end
         RX_DATA: begin
            if (beat) begin
               // Memory is written immediately; a bad checksum later only
               // withholds the CPU release, it does not undo writes.
               mem_we_next    = 1'b1;
               mem_addr_next  = addr_reg;
               mem_wdata_next = s_data;
               addr_next      = addr_reg + ADDR_W'(1);
               left_next      = left_reg - DATA_W'(1);
               sum_next       = frame_sum;
               if (left_reg == DATA_W'(1)) begin
                  state_next = RX_CKSUM;
               end
            end
         end
         RX_CKSUM: begin
            if (beat) begin
               if (!CKSUM_OK(CKSUM_W'(frame_sum))) begin
                  err_cksum_next = 1'b1;
                  state_next     = ERROR;
               end else if (term_reg) begin
                  boot_pc_next = start_reg;
                  state_next   = RUN;
               end else begin
                  if (seg_count_reg != 8'hFF) begin
                     seg_count_next = seg_count_reg + 8'd1;
                  end
                  state_next = RX_ADDR;
               end
            end
         end
         RUN: begin
            // Halt takes priority over a coincident timeout.
            if (cpu_halt) begin
               state_next = DONE;
            end else if (timer_expired) begin
               err_timeout_next = 1'b1;
               state_next       = ERROR;
            end
         end
         DONE, ERROR: begin
            if (restart) begin
               err_cksum_next   = 1'b0;
               err_timeout_next = 1'b0;
               seg_count_next   = '0;
               state_next       = RX_ADDR;
            end
         end
         default: begin
            state_next = RX_ADDR;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      s_ready_next  = (state_next == RX_ADDR) || (state_next == RX_LEN) ||
                      (state_next == RX_DATA) || (state_next == RX_CKSUM);
      cpu_rstn_next = (state_next == RUN) || (state_next == DONE);
      busy_next     = (state_next != DONE) && (state_next != ERROR);
      done_next     = (state_next == DONE);
   end

   assign s_ready     = s_ready_reg;
   assign mem_we      = mem_we_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign cpu_rstn    = cpu_rstn_reg;
   assign boot_pc     = boot_pc_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign err_cksum   = err_cksum_reg;
   assign err_timeout = err_timeout_reg;
   assign seg_count   = seg_count_reg;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader -- self-checking bench for cpu_boot_loader.
// A frame-level model predicts every memory write (address, data, cycle),
// segment count, boot PC and run outcome; a negedge monitor checks writes.
module tb_cpu_boot_loader;
   import boot_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_rstn;
   logic [7:0]  boot_pc;
   logic        cpu_halt = 1'b0;
   logic [15:0] max_cycles = '0;
   logic        restart = 1'b0;
   logic        busy, done, err_cksum, err_timeout;
   logic [7:0]  seg_count;
   logic [15:0] cycle_count;

   always #5 clk = ~clk;

   cpu_boot_loader #(.DATA_W(8), .ADDR_W(8), .CYC_W(16)) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rstn(cpu_rstn), .boot_pc(boot_pc), .cpu_halt(cpu_halt),
      .max_cycles(max_cycles), .restart(restart), .busy(busy), .done(done),
      .err_cksum(err_cksum), .err_timeout(err_timeout),
      .seg_count(seg_count), .cycle_count(cycle_count)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          words_sent = 0;
   logic [15:0] exp_wr_q[$];     // {addr, data} in expected write order
   int          beat_q[$];       // cycle index at which each write must show
   logic [7:0]  tb_mem[256];
   int          exp_seg = 0;
   logic [7:0]  exp_pc = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every write must be predicted, in order, one cycle after its beat.
   always @(negedge clk) begin : mon
      logic [15:0] e;
      int          b;
      if (mem_we === 1'b1) begin
         check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
         if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check("wr_addr", mem_addr, e[15:8]);
            check("wr_data", mem_wdata, e[7:0]);
         end
         if (beat_q.size() != 0) begin
            b = beat_q.pop_front();
            check("wr_latency", cyc, b);
         end
         tb_mem[mem_addr] = mem_wdata;
      end
   end

   task automatic step();
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Presents one word, optionally stalling; returns at the negedge before
   // the edge that accepts it.
   task automatic send_word(input logic [7:0] d, input bit is_data, input int stall);
      int tries = 0;
      bit took = 0;
      while (!took && tries < 500) begin
         @(negedge clk);
         tries++;
         if (stall > 0 && $urandom_range(99) < stall) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = d;
            if (s_ready) begin
               took = 1;
               if (is_data) beat_q.push_back(cyc + 1);
            end
         end
      end
      if (!took) check("send_accept", tries, 0);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d[$], input bit corrupt, input int stall);
      logic [7:0] w[$];
      logic [7:0] sum;
      w.push_back(a);
      w.push_back(8'(d.size()));
      foreach (d[i]) w.push_back(d[i]);
      sum = '0;
      foreach (w[i]) sum = sum + w[i];
      w.push_back(corrupt ? 8'(-sum + 8'd1) : 8'(-sum));
      // Model: data lands at consecutive addresses mod 256, even if the frame is bad.
      foreach (d[i]) exp_wr_q.push_back({8'(a + 8'(i)), d[i]});
      if (!corrupt && d.size() == 0) exp_pc = a;
      else if (!corrupt && exp_seg < 255) exp_seg++;
      $display("frame addr=%02h len=%0d corrupt=%0d stall=%0d%%", w[FIELD_ADDR], w[FIELD_LEN], corrupt, stall);
      foreach (w[i]) send_word(w[i], (i >= FIELD_DATA) && (i < w.size() - 1), stall);
      words_sent += w.size();
   endtask

   // Called at the first negedge after the terminator's CKSUM edge.
   task automatic run_cpu(input logic [15:0] mx, input int halt_at);
      int i = 0;
      bit halted = 0, timed = 0;
      max_cycles = mx;
      check("run_cpu_rstn", cpu_rstn, 1);
      check("run_s_ready", s_ready, 0);
      check("run_boot_pc", boot_pc, exp_pc);
      check("run_count0", cycle_count, 0);
      while (!halted && !timed && i < 2000) begin
         cpu_halt = (i == halt_at);
         restart  = (i == 0);            // must be ignored while running
         @(negedge clk);
         if (cpu_halt) halted = 1;
         else if (mx != 0 && i == int'(mx) - 1) timed = 1;
         i++;
      end
      cpu_halt = 1'b0;
      restart  = 1'b0;
      $display("run max=%0d halt_at=%0d -> cycles=%0d halted=%0d timeout=%0d", mx, halt_at, i, halted, timed);
      check("run_bounded", 32'(halted || timed), 1);
      check("run_done", done, 32'(halted));
      check("run_err_timeout", err_timeout, 32'(timed));
      check("run_cpu_rstn_after", cpu_rstn, 32'(halted));
      check("run_busy", busy, 0);
      check("run_cycles", cycle_count, i);
      step();
      check("run_cycles_frozen", cycle_count, i);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      exp_seg = 0;
      check("rs_s_ready", s_ready, 1);
      check("rs_busy", busy, 1);
      check("rs_done", done, 0);
      check("rs_err", {err_cksum, err_timeout}, 0);
      check("rs_seg", seg_count, 0);
      check("rs_cycles", cycle_count, 0);
      check("rs_cpu_rstn", cpu_rstn, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check("rst_mem_we", mem_we, 0);
      check("rst_cpu_rstn", cpu_rstn, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_busy", busy, 1);
      check("rst_done", done, 0);
      check("rst_seg", seg_count, 0);
      check("rst_cycles", cycle_count, 0);
      check("rst_err", {err_cksum, err_timeout}, 0);
      rstn = 1'b1;
      exp_seg = 0;
   endtask

   initial begin : main
      logic [7:0] d[$];
      logic [7:0] e[$];
      logic [7:0] snap[16];
      int c0, w0;

      repeat (3) @(negedge clk);
      check("r_s_ready", s_ready, 1);
      check("r_mem_we", mem_we, 0);
      check("r_mem_addr", mem_addr, 0);
      check("r_mem_wdata", mem_wdata, 0);
      check("r_cpu_rstn", cpu_rstn, 0);
      check("r_boot_pc", boot_pc, 0);
      check("r_busy", busy, 1);
      check("r_done", done, 0);
      check("r_err", {err_cksum, err_timeout}, 0);
      check("r_seg", seg_count, 0);
      check("r_cycles", cycle_count, 0);
      rstn = 1'b1;

      // Two segments then terminator, back to back.
      c0 = cyc;
      w0 = words_sent;
      d = {8'hC0, 8'h03, 8'hC1, 8'h04, 8'h00, 8'hA1};
      send_frame(8'h00, d, 0, 0);
      d = {8'hC3, 8'h99};
      send_frame(8'h20, d, 0, 0);
      e.delete();
      send_frame(8'h00, e, 0, 0);
      check("t1_rstn_before", cpu_rstn, 0);
      step();
      check("t1_no_gap", cyc - c0, words_sent - w0 + 1);
      check("t1_seg", seg_count, 2);
      check("t1_boot_pc", boot_pc, 8'h00);
      run_cpu(16'd0, 7);
      do_restart();

      // Corrupted checksum on the second frame.
      d = {8'h11, 8'h22, 8'h33};
      send_frame(8'h80, d, 0, 0);
      d = {8'h44, 8'h55};
      send_frame(8'h90, d, 1, 0);
      step();
      check("ck_err", err_cksum, 1);
      check("ck_busy", busy, 0);
      check("ck_done", done, 0);
      check("ck_s_ready", s_ready, 0);
      check("ck_cpu_rstn", cpu_rstn, 0);
      check("ck_seg", seg_count, exp_seg);
      repeat (4) step();
      check("ck_cpu_rstn_hold", cpu_rstn, 0);
      do_restart();

      // Address wrap, then timeout.
      d = {8'h11, 8'h22, 8'h33};
      send_frame(8'hFE, d, 0, 0);
      send_frame(8'hFE, e, 0, 0);
      step();
      run_cpu(16'd10, -1);
      check("to_cycles10", cycle_count, 10);
      do_restart();

      // Halt on the timeout cycle.
      send_frame(8'h33, e, 0, 0);
      step();
      run_cpu(16'd10, 9);
      do_restart();

      // 16-word segment without and with stalls must give the same memory.
      d.delete();
      for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
      send_frame(8'h40, d, 0, 0);
      step();
      for (int i = 0; i < 16; i++) begin
         snap[i] = tb_mem[8'h40 + i];
         tb_mem[8'h40 + i] = '0;
      end
      send_frame(8'h40, d, 0, 50);
      step();
      for (int i = 0; i < 16; i++) check("stall_mem", tb_mem[8'h40 + i], snap[i]);
      send_frame(8'h40, e, 0, 50);
      step();
      run_cpu(16'd0, 3);
      do_restart();

      // Random frames with random stalls, then a random run.
      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < 3; f++) begin
            d.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) d.push_back(8'($urandom));
            send_frame(8'($urandom), d, 0, 30);
         end
         send_frame(8'($urandom), e, 0, 30);
         step();
         check("rnd_seg", seg_count, exp_seg);
         run_cpu($urandom_range(1) ? 16'($urandom_range(5, 30)) : 16'd0, $urandom_range(0, 40));
         do_restart();
      end

      // Reset mid-segment, then a clean load.
      exp_wr_q.push_back({8'h60, 8'hA5});
      exp_wr_q.push_back({8'h61, 8'h5A});
      send_word(8'h60, 0, 0);
      send_word(8'h05, 0, 0);
      send_word(8'hA5, 1, 0);
      send_word(8'h5A, 1, 0);
      do_reset();
      d = {8'h01, 8'h02, 8'h03};
      send_frame(8'h60, d, 0, 0);
      send_frame(8'h60, e, 0, 0);
      step();
      check("rl_seg", seg_count, 1);
      run_cpu(16'd0, 2);

      repeat (3) step();
      check("wr_all_seen", exp_wr_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_boot_loader.md
# cpu_boot_loader

Synthesizable program loader and run supervisor for the pipelined CPU core. It receives framed program segments over a valid/ready word stream, writes them into CPU memory through a dedicated write port, and holds the core in reset until a terminator frame arrives. It then releases the core, counts execution cycles, and reports halt, checksum error or timeout. It replaces hierarchical memory pokes in benches and serves as the on-chip boot path.

## Interface
- DATA_W, 8: stream word width and memory data width.
- ADDR_W, 8: memory address width; must satisfy ADDR_W <= DATA_W.
- CYC_W, 16: width of the cycle counter and the timeout limit.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- cpu_rstn  out  1  active-low reset to the CPU core.
- boot_pc  out  ADDR_W  CPU start address, taken from the terminator frame.
- cpu_halt  in  1  CPU reports that it has halted.
- max_cycles  in  CYC_W  run timeout limit; 0 disables the timeout.
- restart  in  1  single-cycle request to return to load mode from DONE or ERROR.
- busy  out  1  high in every state except DONE and ERROR.
- done  out  1  high in DONE.
- err_cksum  out  1  sticky; set when a frame fails its checksum.
- err_timeout  out  1  sticky; set when the run times out.
- seg_count  out  8  count of good data frames, saturating at 255.
- cycle_count  out  CYC_W  cycles spent in RUN.

## Operation
- Frame format: ADDR, LEN, LEN data words, CKSUM.
  - A frame is good when the mod-2^DATA_W sum of all of its words, CKSUM included, equals 0.
  - ADDR uses its low ADDR_W bits.
  - A frame with LEN=0 is the terminator.
- States: RX_ADDR, RX_LEN, RX_DATA, RX_CKSUM, RUN, DONE, ERROR.
- Transitions:
  - RX_ADDR -> RX_LEN.
  - RX_LEN -> RX_DATA when LEN != 0; RX_LEN -> RX_CKSUM when LEN = 0.
  - RX_DATA -> RX_CKSUM after LEN words.
  - RX_CKSUM, bad checksum -> ERROR, with err_cksum set.
  - RX_CKSUM, good checksum, LEN != 0 -> RX_ADDR, and seg_count increments.
  - RX_CKSUM, good checksum, LEN = 0 -> RUN, and boot_pc is loaded with ADDR.
  - RUN -> DONE on cpu_halt.
  - RUN -> ERROR with err_timeout set when max_cycles != 0 and cycle_count = max_cycles - 1.
  - DONE or ERROR -> RX_ADDR on restart, which clears the error flags, seg_count and cycle_count.
  - restart has no effect in any other state.
- Handshake:
  - A word transfers when s_valid & s_ready.
  - s_ready = 1 in the RX_* states and 0 in all other states.
  - Stalls (s_valid=0) are allowed between any two words.
- Data path:
  - Each accepted data word is written to the current address.
  - The address increments modulo 2^ADDR_W, so a segment may wrap past the top of memory.
  - Writes are committed before the checksum is checked. A bad frame can therefore leave partial memory contents; the CPU is never released in that case.
- CPU control:
  - cpu_rstn = 0 in the RX_* states and in ERROR.
  - cpu_rstn = 1 in RUN and in DONE, so the core state stays inspectable after halt.
  - cycle_count increments on every RUN cycle and freezes on exit from RUN.
- Simultaneous cpu_halt and timeout in the same cycle: halt wins, and the state goes to DONE.

## Timing
- Reset values:
  - state RX_ADDR; s_ready 1.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - cpu_rstn 0, boot_pc 0.
  - busy 1, done 0, both error flags 0, seg_count 0, cycle_count 0.
- Reset asserted mid-load or mid-run returns the block to these values on the next edge.
- All outputs are registered.
- A data word accepted at edge N produces mem_we=1 with its address and data during cycle N+1, one cycle after the beat. No writes occur outside RX_DATA beats.
- Terminator CKSUM accepted at edge N:
  - RUN and cpu_rstn=1 from cycle N+1.
  - cycle_count reads 1 after the first RUN edge.
- Back-to-back frames lose no cycles: s_ready stays 1 across frame boundaries.

## Structure
- Package boot_pkg holds:
  - the state enum;
  - the frame field position constants;
  - a CKSUM_OK helper function.
- One sub-module, boot_run_timer, holds the RUN cycle counter and the timeout compare:
  - inputs: enable, clear, max_cycles;
  - outputs: count, expired.
- All other logic lives in a single FSM and datapath.

## Test plan
- Two segments, then terminator:
  - stimulus: frame {00,06,C0,03,C1,04,00,A1,cs}, frame {20,02,C3,99,cs}, frame {00,00,00}; each cs makes its frame sum to 0.
  - required: mem[0..5] and mem[0x20..0x21] written; seg_count=2; boot_pc=00; cpu_rstn rises the cycle after the final word.
- Corrupted checksum on the second frame:
  - required: err_cksum=1, state ERROR, cpu_rstn stays 0, s_ready=0.
- Address wrap:
  - stimulus: frame {FE,03,11,22,33,cs}.
  - required: writes to FE, FF, 00 in that order.
- Timeout:
  - stimulus: max_cycles=10, cpu_halt held 0.
  - required: err_timeout=1 with cycle_count=10, and cpu_rstn=0 on the following cycle.
- Halt coinciding with the timeout cycle:
  - required: done=1, err_timeout=0.
  - then pulse restart: state RX_ADDR, flags cleared.
- Random s_valid stalls (about 50 %) during a 16-word segment:
  - required: memory contents identical to the no-stall run.
- Reset mid-segment:
  - required: mem_we=0 and cpu_rstn=0 next cycle.
  - a following clean load then succeeds.
